fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS datapath. It owns the program counter, drives the instruction-memory address, computes PC+4, and holds the IF/ID pipeline register feeding decode. It accepts stall requests from hazard detection and branch redirects from the execute side. It provides a RUN/HALTED state machine so simulation ends cleanly on a halt opcode.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_OPCODE, 6'b111111, opcode field (bits 31:26) recognised as halt.

Ports:
- CLK, input, 1, single clock; all state updates on the rising edge.
- RST, input, 1, reset; synchronous and active-high.
- StallF, input, 1, hazard stall; holds the PC and the IF/ID register.
- FlushD, input, 1, replaces the IF/ID contents with a bubble.
- BranchTaken, input, 1, redirect request from execute.
- BranchTarget, input, 32, redirect address; bits [1:0] are ignored and forced to 0.
- InsAddr, output, 32, address to instruction memory; equals PCF.
- InsData, input, 32, instruction word; combinational read of InsAddr.
- PCPlus4D, output, 32, registered PC+4 of the instruction held in IF/ID.
- InstrD, output, 32, registered instruction; NOP is 32'h0000_0000.
- ValidD, output, 1, high when InstrD is a real instruction.
- Halted, output, 1, high in the HALTED state.

## Operation

- Next-PC priority, highest first: RST → RESET_PC; BranchTaken → {BranchTarget[31:2],2'b00}; StallF or HALTED → hold; otherwise PCF+4, which wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- IF/ID update priority, highest first:
  - RST → InstrD=0, PCPlus4D=0, ValidD=0.
  - FlushD or BranchTaken → NOP bubble (InstrD=0, ValidD=0), PCPlus4D=0.
  - StallF → hold all three outputs.
  - HALTED → NOP bubble.
  - Otherwise load InsData, PCF+4, and ValidD=1.
- States RUN and HALTED; reset state is RUN.
  - RUN→HALTED: InsData[31:26]==HALT_OPCODE, and no StallF, FlushD, BranchTaken or RST in that cycle. The halt word itself is loaded into IF/ID with ValidD=1 in that cycle. The PC does not advance.
  - HALTED→RUN: on BranchTaken, which redirects the PC in that cycle. A halt fetched in a branch shadow is therefore cancelled.
  - HALTED→RUN on RST.
- A stall and a branch in the same cycle: the branch wins, and the stall is dropped for fetch.
- Reset while HALTED or mid-stall fully restores the reset state.

## Timing

- InsAddr is combinational from PCF, with zero latency.
- Fetch-to-decode latency is 1 cycle: an instruction addressed in cycle n appears on InstrD in cycle n+1.
- Branch penalty is 1 bubble: the target is fetched in the cycle after BranchTaken and is on InstrD 2 cycles after it.
- Halted rises in the cycle after the halt word is fetched.
- Reset values: InsAddr=RESET_PC, InstrD=0, PCPlus4D=0, ValidD=0, Halted=0; the PerfStall and PerfFlush counters are 0.

## Configuration

- FETCH_PERF_CNT_EN, when defined, adds two output ports:
  - PerfStall[31:0]: counts cycles with StallF=1 and BranchTaken=0, in RUN.
  - PerfFlush[31:0]: counts cycles with FlushD or BranchTaken=1.
  - Both counters saturate at 32'hFFFF_FFFF and clear on RST.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure

- The shared pipeline package holds:
  - NOP_INSTR (32'h0);
  - the default HALT_OPCODE;
  - the fetch state enum (RUN, HALTED);
  - the PC width constant used by all pipeline registers.
- One sub-module, fetch_perf_ctr: a saturating 32-bit counter with synchronous clear, instantiated twice under FETCH_PERF_CNT_EN.
- The PC and IF/ID registers stay inline.

## Test plan

- Reset then run: RST for 2 cycles, then an IMem of sequential adds.
  - InsAddr shows 0, 4, 8, … each cycle.
  - InstrD lags by 1 cycle, with PCPlus4D = 4, 8, 12.
  - ValidD=0 in the first post-reset cycle.
- Stall: StallF=1 for 3 cycles at PC=0x10.
  - InsAddr holds 0x10, and InstrD/PCPlus4D hold the word fetched from 0x0C.
  - Fetch resumes at 0x14.
- Branch with stall in the same cycle: BranchTaken=1, BranchTarget=0x43, StallF=1 at PC=0x20.
  - Next InsAddr is 0x40, and InstrD becomes a bubble (ValidD=0).
  - The stall is ignored.
- Halt and recovery: place 32'hFC00_0000 at 0x18.
  - InstrD = FC00_0000 with ValidD=1, then bubbles follow.
  - Halted=1 and InsAddr stays 0x18.
  - A later BranchTaken to 0x100 clears Halted and fetches 0x100.
- Halt in branch shadow: halt word at 0x24, BranchTaken to 0x80 in the cycle 0x24 is fetched.
  - Halted stays 0 and the halt word never reaches ValidD=1.
- With FETCH_PERF_CNT_EN:
  - 5 stall cycles and 2 flush cycles give PerfStall=5 and PerfFlush=2.
  - A counter forced to 32'hFFFF_FFFF stays there under further events.
  - RST clears both counters to 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline package: widths, NOP encoding, default halt opcode and fetch FSM states.
package fetch_stage_pkg;

    localparam int unsigned PC_W     = 32;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned CNT_W    = 32;

    localparam logic [INSTR_W-1:0]  NOP_INSTR           = 32'h0000_0000;
    localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEFAULT = 6'b111111;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc_plus4;
        logic               valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_perf_ctr.sv
// Saturating event counter with synchronous clear; used for fetch stall/flush statistics.
module fetch_perf_ctr
    import fetch_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, IF/ID register, RUN/HALTED control.
// Optional stall/flush performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0]     RESET_PC    = 32'h0000_0000,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
)(
    input  logic               CLK,
    input  logic               RST,
    input  logic               StallF,
    input  logic               FlushD,
    input  logic               BranchTaken,
    input  logic [PC_W-1:0]    BranchTarget,
    output logic [PC_W-1:0]    InsAddr,
    input  logic [INSTR_W-1:0] InsData,
    output logic [PC_W-1:0]    PCPlus4D,
    output logic [INSTR_W-1:0] InstrD,
    output logic               ValidD,
    output logic               Halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   PerfStall,
    output logic [CNT_W-1:0]   PerfFlush
`endif
);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    ifid_t             ifid_q, ifid_d;
    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   branch_pc;
    logic              halt_hit;

    assign pc_plus4  = pc_q + PC_W'(4);
    assign branch_pc = BranchTarget & ~PC_W'(3);
    assign halt_hit  = (InsData[INSTR_W-1 -: OPCODE_W] == HALT_OPCODE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            ifid_q  <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
        end
    end

    // Next-PC, next-state and IF/ID selection; a redirect always beats stall and halt
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;

        if (BranchTaken) begin
            pc_d    = branch_pc;
            state_d = RUN;
        end else if (StallF || (state_q == HALTED)) begin
            pc_d = pc_q;
        end else if (halt_hit && !FlushD) begin
            pc_d    = pc_q;
            state_d = HALTED;
        end else begin
            pc_d = pc_plus4;
        end

        if (FlushD || BranchTaken) begin
            ifid_d = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else if (StallF) begin
            ifid_d = ifid_q;
        end else if (state_q == HALTED) begin
            ifid_d = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else begin
            ifid_d = '{instr: InsData, pc_plus4: pc_plus4, valid: 1'b1};
        end
    end

    assign InsAddr  = pc_q;
    assign InstrD   = ifid_q.instr;
    assign PCPlus4D = ifid_q.pc_plus4;
    assign ValidD   = ifid_q.valid;
    assign Halted   = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic stall_evt;
    logic flush_evt;

    assign stall_evt = StallF && !BranchTaken && (state_q == RUN);
    assign flush_evt = FlushD || BranchTaken;

    fetch_perf_ctr u_stall_ctr (
        .clk (CLK),
        .rst (RST),
        .inc (stall_evt),
        .cnt (PerfStall)
    );

    fetch_perf_ctr u_flush_ctr (
        .clk (CLK),
        .rst (RST),
        .inc (flush_evt),
        .cnt (PerfFlush)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage; perf-counter scenario is built when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        StallF;
    logic        FlushD;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] InsAddr;
    logic [31:0] InsData;
    logic [31:0] PCPlus4D;
    logic [31:0] InstrD;
    logic        ValidD;
    logic        Halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] PerfStall;
    logic [31:0] PerfFlush;
`endif

    logic [31:0] halt_at = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] addr;
        logic        halted;
    } obs_t;

    obs_t exp_q[$];
    obs_t got_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    // Instruction memory: addi-style words tagged with their address, one optional halt word
    assign InsData = (InsAddr == halt_at) ? 32'hFC00_0000 : (32'h2108_0000 | {16'h0, InsAddr[15:0]});

    fetch_stage dut (
        .CLK          (CLK),
        .RST          (RST),
        .StallF       (StallF),
        .FlushD       (FlushD),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .InsAddr      (InsAddr),
        .InsData      (InsData),
        .PCPlus4D     (PCPlus4D),
        .InstrD       (InstrD),
        .ValidD       (ValidD),
        .Halted       (Halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .PerfStall    (PerfStall),
        .PerfFlush    (PerfFlush)
`endif
    );

    function automatic logic [31:0] w(input logic [31:0] a);
        return (a == halt_at) ? 32'hFC00_0000 : (32'h2108_0000 | {16'h0, a[15:0]});
    endfunction

    task automatic push(input logic [31:0] i, input logic [31:0] p, input logic v,
                        input logic [31:0] a, input logic h);
        obs_t e;
        e.instr = i; e.pc4 = p; e.valid = v; e.addr = a; e.halted = h;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic s, input logic f, input logic b, input logic [31:0] t);
        obs_t o;
        StallF = s; FlushD = f; BranchTaken = b; BranchTarget = t;
        @(posedge CLK);
        #1;
        o.instr = InstrD; o.pc4 = PCPlus4D; o.valid = ValidD; o.addr = InsAddr; o.halted = Halted;
        got_q.push_back(o);
        StallF = 1'b0; FlushD = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    endtask

    task automatic test_reset;
        obs_t e, g;
        exp_q.delete(); got_q.delete();
        RST = 1'b1;
        push(32'h0, 32'h0, 1'b0, 32'h0, 1'b0); step(1'b0, 1'b0, 1'b0, 32'h0);
        push(32'h0, 32'h0, 1'b0, 32'h0, 1'b0); step(1'b1, 1'b1, 1'b0, 32'h0);
        RST = 1'b0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL reset: no observation, want %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL reset: got instr=%h pc4=%h v=%b addr=%h h=%b want instr=%h pc4=%h v=%b addr=%h h=%b",
                             g.instr, g.pc4, g.valid, g.addr, g.halted, e.instr, e.pc4, e.valid, e.addr, e.halted);
                end
            end
        end
    endtask

    task automatic test_run_and_stall;
        obs_t e, g;
        exp_q.delete(); got_q.delete();
        for (int k = 0; k < 4; k++) begin
            push(w(32'(4 * k)), 32'(4 * k + 4), 1'b1, 32'(4 * k + 4), 1'b0);
            step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        for (int k = 0; k < 3; k++) begin
            push(w(32'h0C), 32'h10, 1'b1, 32'h10, 1'b0);
            step(1'b1, 1'b0, 1'b0, 32'h0);
        end
        for (int pc = 32'h10; pc < 32'h20; pc += 4) begin
            push(w(32'(pc)), 32'(pc + 4), 1'b1, 32'(pc + 4), 1'b0);
            step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL run_stall: no observation, want %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL run_stall: got instr=%h pc4=%h v=%b addr=%h h=%b want instr=%h pc4=%h v=%b addr=%h h=%b",
                             g.instr, g.pc4, g.valid, g.addr, g.halted, e.instr, e.pc4, e.valid, e.addr, e.halted);
                end
            end
        end
    endtask

    task automatic test_branch_with_stall;
        obs_t e, g;
        exp_q.delete(); got_q.delete();
        push(32'h0, 32'h0, 1'b0, 32'h40, 1'b0);            step(1'b1, 1'b0, 1'b1, 32'h43);
        push(w(32'h40), 32'h44, 1'b1, 32'h44, 1'b0);       step(1'b0, 1'b0, 1'b0, 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL branch_stall: no observation, want %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL branch_stall: got instr=%h pc4=%h v=%b addr=%h h=%b want instr=%h pc4=%h v=%b addr=%h h=%b",
                             g.instr, g.pc4, g.valid, g.addr, g.halted, e.instr, e.pc4, e.valid, e.addr, e.halted);
                end
            end
        end
    endtask

    task automatic test_halt_recovery;
        obs_t e, g;
        exp_q.delete(); got_q.delete();
        halt_at = 32'h18;
        push(32'h0, 32'h0, 1'b0, 32'h10, 1'b0);            step(1'b0, 1'b0, 1'b1, 32'h10);
        push(w(32'h10), 32'h14, 1'b1, 32'h14, 1'b0);       step(1'b0, 1'b0, 1'b0, 32'h0);
        push(w(32'h14), 32'h18, 1'b1, 32'h18, 1'b0);       step(1'b0, 1'b0, 1'b0, 32'h0);
        push(32'hFC00_0000, 32'h1C, 1'b1, 32'h18, 1'b1);   step(1'b0, 1'b0, 1'b0, 32'h0);
        push(32'h0, 32'h0, 1'b0, 32'h18, 1'b1);            step(1'b0, 1'b0, 1'b0, 32'h0);
        push(32'h0, 32'h0, 1'b0, 32'h18, 1'b1);            step(1'b1, 1'b0, 1'b0, 32'h0);
        push(32'h0, 32'h0, 1'b0, 32'h18, 1'b1);            step(1'b0, 1'b0, 1'b0, 32'h0);
        push(32'h0, 32'h0, 1'b0, 32'h100, 1'b0);           step(1'b0, 1'b0, 1'b1, 32'h100);
        push(w(32'h100), 32'h104, 1'b1, 32'h104, 1'b0);    step(1'b0, 1'b0, 1'b0, 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL halt: no observation, want %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL halt: got instr=%h pc4=%h v=%b addr=%h h=%b want instr=%h pc4=%h v=%b addr=%h h=%b",
                             g.instr, g.pc4, g.valid, g.addr, g.halted, e.instr, e.pc4, e.valid, e.addr, e.halted);
                end
            end
        end
    endtask

    task automatic test_halt_shadow_and_flush;
        obs_t e, g;
        exp_q.delete(); got_q.delete();
        halt_at = 32'h24;
        push(32'h0, 32'h0, 1'b0, 32'h20, 1'b0);            step(1'b0, 1'b0, 1'b1, 32'h20);
        push(w(32'h20), 32'h24, 1'b1, 32'h24, 1'b0);       step(1'b0, 1'b0, 1'b0, 32'h0);
        push(32'h0, 32'h0, 1'b0, 32'h80, 1'b0);            step(1'b0, 1'b0, 1'b1, 32'h80);
        push(w(32'h80), 32'h84, 1'b1, 32'h84, 1'b0);       step(1'b0, 1'b0, 1'b0, 32'h0);
        // a flushed halt word is not a halt, and the PC keeps advancing
        push(32'h0, 32'h0, 1'b0, 32'h24, 1'b0);            step(1'b0, 1'b0, 1'b1, 32'h24);
        push(32'h0, 32'h0, 1'b0, 32'h28, 1'b0);            step(1'b0, 1'b1, 1'b0, 32'h0);
        push(w(32'h28), 32'h2C, 1'b1, 32'h2C, 1'b0);       step(1'b0, 1'b0, 1'b0, 32'h0);
        push(32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b0);     step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        push(32'h2108_FFFC, 32'h0, 1'b1, 32'h0, 1'b0);     step(1'b0, 1'b0, 1'b0, 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL shadow_flush: no observation, want %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL shadow_flush: got instr=%h pc4=%h v=%b addr=%h h=%b want instr=%h pc4=%h v=%b addr=%h h=%b",
                             g.instr, g.pc4, g.valid, g.addr, g.halted, e.instr, e.pc4, e.valid, e.addr, e.halted);
                end
            end
        end
    endtask

    task automatic test_reset_while_halted;
        obs_t e, g;
        exp_q.delete(); got_q.delete();
        push(32'h0, 32'h0, 1'b0, 32'h24, 1'b0);            step(1'b0, 1'b0, 1'b1, 32'h24);
        push(32'hFC00_0000, 32'h28, 1'b1, 32'h24, 1'b1);   step(1'b0, 1'b0, 1'b0, 32'h0);
        RST = 1'b1;
        push(32'h0, 32'h0, 1'b0, 32'h0, 1'b0);             step(1'b1, 1'b0, 1'b0, 32'h0);
        RST = 1'b0;
        push(w(32'h0), 32'h4, 1'b1, 32'h4, 1'b0);          step(1'b0, 1'b0, 1'b0, 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL reset_halted: no observation, want %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL reset_halted: got instr=%h pc4=%h v=%b addr=%h h=%b want instr=%h pc4=%h v=%b addr=%h h=%b",
                             g.instr, g.pc4, g.valid, g.addr, g.halted, e.instr, e.pc4, e.valid, e.addr, e.halted);
                end
            end
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_counters;
        halt_at = 32'hFFFF_FFFF;
        RST = 1'b1; step(1'b0, 1'b0, 1'b0, 32'h0); RST = 1'b0;
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (PerfStall !== 32'd5 || PerfFlush !== 32'd2) begin
            errors++; $display("FAIL perf_count: got stall=%0d flush=%0d want stall=5 flush=2", PerfStall, PerfFlush);
        end
        force dut.u_stall_ctr.cnt = 32'hFFFF_FFFF;
        #1;
        release dut.u_stall_ctr.cnt;
        for (int k = 0; k < 2; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (PerfStall !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL perf_saturate: got stall=%h want ffffffff", PerfStall);
        end
        RST = 1'b1; step(1'b0, 1'b0, 1'b0, 32'h0); RST = 1'b0;
        checks++;
        if (PerfStall !== 32'h0 || PerfFlush !== 32'h0) begin
            errors++; $display("FAIL perf_clear: got stall=%h flush=%h want 0/0", PerfStall, PerfFlush);
        end
        got_q.delete();
    endtask
`endif

    initial begin
        RST = 1'b1; StallF = 1'b0; FlushD = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
        test_reset;
        test_run_and_stall;
        test_branch_with_stall;
        test_halt_recovery;
        test_halt_shadow_and_flush;
        test_reset_while_halted;
`ifdef FETCH_PERF_CNT_EN
        test_perf_counters;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
